// File: rtl/blockmem_ctrl.sv
// Block-transfer backing-memory controller: accepts one whole-block refill or writeback,
// waits LATENCY cycles, then streams the block one word per cycle to/from word storage.
module blockmem_ctrl #(
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int LATENCY     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [31:0]                      req_addr,
    input  logic [WORD_SIZE*BLOCK_WORDS-1:0] req_wdata,
    output logic                             resp_valid,
    output logic [WORD_SIZE*BLOCK_WORDS-1:0] resp_rdata,
    output logic                             busy
);

    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int BYTE_W = $clog2(WORD_SIZE / 8);
    localparam int BLK_W  = ADDR_WIDTH - BEAT_W;
    localparam int CNT_W  = BEAT_W + 1;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] DRAIN    = CNT_W'(BLOCK_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

    // Ascending word index puts beat 0 on the MSB side of the packed block.
    typedef logic [0:BLOCK_WORDS-1][WORD_SIZE-1:0] block_t;

    state_t                r_state;
    logic                  r_write;
    logic [BLK_W-1:0]      r_blk;
    logic [CNT_W-1:0]      r_beat;
    logic [LAT_W-1:0]      r_lat;
    block_t                r_buf;
    block_t                r_rdata;
    logic                  r_ready;
    logic                  r_resp;
    logic                  r_busy;
    logic [WORD_SIZE-1:0]  r_mem [0:(2**ADDR_WIDTH)-1];
    logic [WORD_SIZE-1:0]  r_rd_word;

    logic [BEAT_W-1:0]     w_beat_idx;
    logic [BEAT_W-1:0]     w_prev_idx;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_mem_en;
    block_t                w_buf_next;
    logic                  w_unused;

    assign req_ready  = r_ready;
    assign resp_valid = r_resp;
    assign resp_rdata = r_rdata;
    assign busy       = r_busy;
    assign w_unused   = ^{req_addr[31:ADDR_WIDTH+BYTE_W], req_addr[BYTE_W+BEAT_W-1:0]};

    // Storage reads are registered, so each read word lands in the buffer one cycle
    // after its access; XFER spends one extra drain cycle to collect the last word.
    always_comb begin
        w_beat_idx = r_beat[BEAT_W-1:0];
        w_prev_idx = BEAT_W'(r_beat - 1'b1);
        w_mem_addr = {r_blk, w_beat_idx};
        w_mem_en   = (r_state == XFER) && (r_beat != DRAIN);
        w_buf_next = r_buf;
        if ((r_state == XFER) && !r_write && (r_beat != '0)) begin
            w_buf_next[w_prev_idx] = r_rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_en) begin
            if (r_write) begin
                r_mem[w_mem_addr] <= r_buf[w_beat_idx];
            end else begin
                r_rd_word <= r_mem[w_mem_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_blk   <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
            r_ready <= 1'b1;
            r_resp  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_blk   <= req_addr[ADDR_WIDTH+BYTE_W-1 -: BLK_W];
                        r_beat  <= '0;
                        r_lat   <= LAT_INIT;
                        if (req_write) begin
                            r_buf <= req_wdata;
                        end
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (LATENCY == 0) ? XFER : WAIT;
                    end
                end
                WAIT: begin
                    if (r_lat == '0) begin
                        r_state <= XFER;
                    end else begin
                        r_lat <= r_lat - 1'b1;
                    end
                end
                XFER: begin
                    r_buf <= w_buf_next;
                    if (r_beat == DRAIN) begin
                        r_state <= RESP;
                        r_resp  <= 1'b1;
                        if (!r_write) begin
                            r_rdata <= w_buf_next;
                        end
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
